// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a one-entry skid buffer.
// Latency: an accepted entry reaches the outputs one cycle later.
// Backpressure: in_ready is registered and drops while the skid holds an entry.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   flush             drops every held entry (and any entry accepted that cycle)
//   in_valid/in_ready MEM-side handshake; payload alu_in, mem_in, waddr_in,
//                     jal_in, memtoReg_in, wen_in, pc_in
//   out_valid/out_ready WB-side handshake; payload *_out driven from the main register
// Optional feature (macro MEM_WB_FWD_EN): fwd_valid, fwd_addr, fwd_data expose
//   the value the main-register entry will write back, for operand forwarding.
module mem_wb_skid #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int ISIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] alu_in,
  input  logic [DSIZE-1:0] mem_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             jal_in,
  input  logic             memtoReg_in,
  input  logic             wen_in,
  input  logic [ISIZE-1:0] pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] alu_out,
  output logic [DSIZE-1:0] mem_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             jal_out,
  output logic             memtoReg_out,
  output logic             wen_out,
  output logic [ISIZE-1:0] pc_out
`ifdef MEM_WB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [ASIZE-1:0] fwd_addr,
  output logic [DSIZE-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [DSIZE-1:0] alu;
    logic [DSIZE-1:0] mem;
    logic [ASIZE-1:0] waddr;
    logic             jal;
    logic             mem_to_reg;
    logic             wen;
    logic [ISIZE-1:0] pc;
  } entry_t;

  // The state encodes both valid bits: main valid = ONE|FULL, skid valid = FULL.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_ent;
  logic   in_ready_q;
  logic   main_vld;
  logic   in_fire;
  logic   out_fire;

  assign in_ent = '{alu: alu_in, mem: mem_in, waddr: waddr_in, jal: jal_in,
                    mem_to_reg: memtoReg_in, wen: wen_in, pc: pc_in};

  assign main_vld = (state == ONE) || (state == FULL);
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = main_vld && out_ready;

  always_comb begin
    state_nxt = state;
    main_d    = main_q;
    skid_d    = skid_q;
    if (flush) begin
      // Flush overrides both handshakes; wen is cleared so an empty main
      // register never looks like a pending write.
      state_nxt  = EMPTY;
      main_d.wen = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_d    = in_ent;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_ent;
          end else if (in_fire) begin
            skid_d    = in_ent;
            state_nxt = FULL;
          end else if (out_fire) begin
            main_d.wen = 1'b0;
            state_nxt  = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low in FULL, so only the output side can move.
          if (out_fire) begin
            main_d    = skid_q;
            state_nxt = ONE;
          end
        end
        default: begin
          main_d.wen = 1'b0;
          state_nxt  = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered copy of "skid empty next cycle".
      in_ready_q <= (state_nxt != FULL);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_vld;
  assign alu_out      = main_q.alu;
  assign mem_out      = main_q.mem;
  assign waddr_out    = main_q.waddr;
  assign jal_out      = main_q.jal;
  assign memtoReg_out = main_q.mem_to_reg;
  assign wen_out      = main_q.wen;
  assign pc_out       = main_q.pc;

`ifdef MEM_WB_FWD_EN
  logic [DSIZE-1:0] pc_ext;

  // Link PC is zero-extended or truncated to the data width.
  generate
    if (ISIZE >= DSIZE) begin : g_pc_trunc
      assign pc_ext = main_q.pc[DSIZE-1:0];
    end else begin : g_pc_zext
      assign pc_ext = {{(DSIZE-ISIZE){1'b0}}, main_q.pc};
    end
  endgenerate

  assign fwd_valid = main_vld && main_q.wen;
  assign fwd_addr  = main_q.waddr;
  assign fwd_data  = main_q.jal        ? pc_ext :
                     main_q.mem_to_reg ? main_q.mem : main_q.alu;
`endif

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;

  localparam int DSIZE = 32;
  localparam int ASIZE = 5;
  localparam int ISIZE = 32;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] alu_in;
  logic [DSIZE-1:0] mem_in;
  logic [ASIZE-1:0] waddr_in;
  logic             jal_in;
  logic             memtoReg_in;
  logic             wen_in;
  logic [ISIZE-1:0] pc_in;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] alu_out;
  logic [DSIZE-1:0] mem_out;
  logic [ASIZE-1:0] waddr_out;
  logic             jal_out;
  logic             memtoReg_out;
  logic             wen_out;
  logic [ISIZE-1:0] pc_out;
`ifdef MEM_WB_FWD_EN
  logic             fwd_valid;
  logic [ASIZE-1:0] fwd_addr;
  logic [DSIZE-1:0] fwd_data;
`endif

  mem_wb_skid #(.DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_in       (alu_in),
    .mem_in       (mem_in),
    .waddr_in     (waddr_in),
    .jal_in       (jal_in),
    .memtoReg_in  (memtoReg_in),
    .wen_in       (wen_in),
    .pc_in        (pc_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_out      (alu_out),
    .mem_out      (mem_out),
    .waddr_out    (waddr_out),
    .jal_out      (jal_out),
    .memtoReg_out (memtoReg_out),
    .wen_out      (wen_out),
    .pc_out       (pc_out)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] sb[$];

  function automatic logic [127:0] pk(input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] m,
                                      input logic [ASIZE-1:0] w, input logic j, input logic r,
                                      input logic e, input logic [ISIZE-1:0] p);
    pk = {24'h0, a, m, w, j, r, e, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected-response producer: every accepted entry is queued, unless the
  // same cycle flushes or resets.
  always @(negedge clk) begin
    if (!rst && !flush && in_valid && in_ready)
      sb.push_back(pk(alu_in, mem_in, waddr_in, jal_in, memtoReg_in, wen_in, pc_in));
  end

  // Monitor: compares every consumed entry against the queue head.
  always @(negedge clk) begin
    logic [127:0] got, exp;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (!out_valid) begin
        n_cmp++;
        if (wen_out !== 1'b0) begin
          n_err++;
          $display("FAIL idle_wen: got %b expected 0", wen_out);
        end
      end
      if (out_valid && out_ready) begin
        got = pk(alu_out, mem_out, waddr_out, jal_out, memtoReg_out, wen_out, pc_out);
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_order: got 0x%0h expected no entry", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL sb_order: got 0x%0h expected 0x%0h", got, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] m,
                        input logic [ASIZE-1:0] w, input logic j, input logic r,
                        input logic e, input logic [ISIZE-1:0] p);
    in_valid    = v;
    alu_in      = a;
    mem_in      = m;
    waddr_in    = w;
    jal_in      = j;
    memtoReg_in = r;
    wen_in      = e;
    pc_in       = p;
  endtask

  task automatic idle_in();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Fill to FULL with two entries while WB stalls.
  task automatic fill_two(input logic [DSIZE-1:0] a0, input logic [DSIZE-1:0] a1);
    out_ready = 1'b0;
    set_in(1'b1, a0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    set_in(1'b1, a1, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 32'h104);
    tick();
    idle_in();
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    idle_in();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu_out", 64'(alu_out), 64'd0);
    chk("rst_wen_out", 64'(wen_out), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);

    // One-cycle latency and full-rate streaming
    out_ready = 1'b1;
    set_in(1'b1, 32'h11, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    chk("first_out_valid", 64'(out_valid), 64'd1);
    chk("first_alu_out", 64'(alu_out), 64'h11);
    chk("first_waddr_out", 64'(waddr_out), 64'd3);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h20 + 32'(i), 32'h0, 5'(4 + i), 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      chk("stream_alu_out", 64'(alu_out), 64'h20 + 64'(i));
    end
    idle_in();
    tick();
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: A then B into a stalled WB
    fill_two(32'h1, 32'h2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_a", 64'(alu_out), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("skid_head_b", 64'(alu_out), 64'h2);
    chk("skid_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("skid_drained", 64'(out_valid), 64'd0);

    // Flush while FULL with an entry offered (in_ready is low here)
    fill_two(32'h5, 32'h6);
    flush = 1'b1;
    set_in(1'b1, 32'h3, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    flush = 1'b0;
    idle_in();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_wen_out", 64'(wen_out), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // Flush in ONE with a real input fire: C must be discarded
    out_ready = 1'b0;
    set_in(1'b1, 32'h7, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    flush = 1'b1;
    set_in(1'b1, 32'h3, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    flush = 1'b0;
    idle_in();
    chk("flush1_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush1_no_ghost", 64'(out_valid), 64'd0);

    // Reset while FULL
    fill_two(32'hA, 32'hB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_alu_out", 64'(alu_out), 64'd0);
    chk("mrst_waddr_out", 64'(waddr_out), 64'd0);
    chk("mrst_pc_out", 64'(pc_out), 64'd0);
    chk("mrst_wen_out", 64'(wen_out), 64'd0);

`ifdef MEM_WB_FWD_EN
    out_ready = 1'b0;
    set_in(1'b1, 32'h99, 32'h55, 5'd10, 1'b1, 1'b0, 1'b1, 32'h40);
    tick();
    idle_in();
    chk("fwd_jal_data", 64'(fwd_data), 64'h40);
    chk("fwd_jal_valid", 64'(fwd_valid), 64'd1);
    chk("fwd_jal_addr", 64'(fwd_addr), 64'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b1, 32'h99, 32'hAB, 5'd11, 1'b0, 1'b1, 1'b1, 32'h44);
    tick();
    idle_in();
    chk("fwd_mem_data", 64'(fwd_data), 64'hAB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b1, 32'h77, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 32'h48);
    tick();
    idle_in();
    chk("fwd_nowen_valid", 64'(fwd_valid), 64'd0);
    chk("fwd_alu_data", 64'(fwd_data), 64'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
`endif

    // Random handshakes against the scoreboard
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        set_in(1'b1, 32'h1000 + 32'(cnt), 32'h2000 + 32'(cnt), 5'(cnt), 1'(cnt % 5 == 0),
               1'(cnt % 3 == 0), 1'(cnt % 2 == 0), 32'h3000 + 32'(cnt));
        cnt++;
      end else begin
        idle_in();
      end
      tick();
    end
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (out_valid || sb.size() != 0); i++) tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
